// File: rtl/maj_tree_pkg.sv
// maj_tree_pkg
// Shared definitions for the pipelined ternary majority tree.
//   maj3        : single-bit three-input majority, applied bit by bit by each node
//   leafCount   : number of leaves (3**levels) for a tree of the given depth
//   nodeCount   : number of nodes at a given level of a tree of the given depth
//   WIDTH_MIN/WIDTH_MAX, LEVELS_MIN/LEVELS_MAX : legal parameter ranges
package maj_tree_pkg;

    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 64;
    localparam int LEVELS_MIN = 1;
    localparam int LEVELS_MAX = 4;

    // Majority of three bits: true when at least two inputs are true.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Nodes at 'level' of a tree 'levels' deep; level 0 holds the leaves.
    function automatic int nodeCount(input int levels, input int level);
        int n;
        n = 1;
        for (int i = level; i < levels; i++) begin
            n = n * 3;
        end
        return n;
    endfunction

    function automatic int leafCount(input int levels);
        return nodeCount(levels, 0);
    endfunction

endpackage

// File: rtl/maj_tree_stage.sv
// maj_tree_stage
// One registered level of the majority tree: NODES majority nodes, each
// reducing three WIDTH-bit children, followed by a data register and a valid bit.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   flush       : synchronous clear of the valid bit
//   load        : stage may take new contents this cycle
//   childValid  : the level below holds a vector
//   childData   : 3*NODES children of WIDTH bits, child i at [i*WIDTH +: WIDTH]
//   nodeValid   : this stage holds a vector
//   nodeData    : NODES registered node results
module maj_tree_stage
    import maj_tree_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int NODES = 1
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     load,
    input  logic                     childValid,
    input  logic [3*NODES*WIDTH-1:0] childData,
    output logic                     nodeValid,
    output logic [NODES*WIDTH-1:0]   nodeData
);

    logic [NODES*WIDTH-1:0] nodeNext;

    // Every node takes children 3j, 3j+1 and 3j+2 and votes bit by bit, so
    // each bit position of the vector forms an independent majority tree.
    always_comb begin
        nodeNext = '0;
        for (int j = 0; j < NODES; j++) begin
            for (int b = 0; b < WIDTH; b++) begin
                nodeNext[j*WIDTH + b] = maj3(childData[(3*j)*WIDTH + b],
                                             childData[(3*j + 1)*WIDTH + b],
                                             childData[(3*j + 2)*WIDTH + b]);
            end
        end
    end

    // Stage register. Flush only drops the valid bit; the data is left alone
    // since nothing downstream looks at it without valid. Data is captured
    // only when a real vector arrives, so an emptying load keeps the last
    // result visible on the output rather than bubble garbage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nodeValid <= 1'b0;
            nodeData  <= '0;
        end else if (flush) begin
            nodeValid <= 1'b0;
        end else if (load) begin
            nodeValid <= childValid;
            if (childValid) begin
                nodeData <= nodeNext;
            end
        end
    end

endmodule

// File: rtl/maj_tree_pipe.sv
// maj_tree_pipe
// Pipelined bitwise ternary majority tree over 3**LEVELS leaf vectors, with
// one register stage per tree level and valid/ready flow control.
// Optional build macro: MAJ_TREE_INV_EN adds the per-leaf complement mask in_inv.
// Ports:
//   clk, rst_n           : clock and asynchronous active-low reset
//   flush                : synchronous clear of all in-flight vectors
//   in_valid / in_ready  : leaf vector handshake
//   in_leaf              : LEAVES*WIDTH bits, leaf i at [i*WIDTH +: WIDTH]
//   in_inv               : per-leaf complement mask (MAJ_TREE_INV_EN only)
//   out_valid / out_ready: result handshake
//   out_data             : WIDTH-bit root result
//   busy                 : any stage holds a vector
module maj_tree_pipe
    import maj_tree_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int LEVELS = 3
)
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [leafCount(LEVELS)*WIDTH-1:0]  in_leaf,
`ifdef MAJ_TREE_INV_EN
    input  logic [leafCount(LEVELS)-1:0]        in_inv,
`endif
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WIDTH-1:0]                    out_data,
    output logic                                busy
);

    localparam int LEAVES = leafCount(LEVELS);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        LEVELS < LEVELS_MIN || LEVELS > LEVELS_MAX) begin : gBadParam
        $error("maj_tree_pipe: WIDTH or LEVELS outside the legal range");
    end

    logic [LEAVES*WIDTH-1:0] leafEff;
    logic [LEVELS-1:0]       stageValid;
    logic [LEVELS-1:0]       stageLoad;

`ifdef MAJ_TREE_INV_EN
    // Complement the selected leaves ahead of the first level of nodes.
    always_comb begin
        leafEff = '0;
        for (int i = 0; i < LEAVES; i++) begin
            leafEff[i*WIDTH +: WIDTH] = in_leaf[i*WIDTH +: WIDTH] ^ {WIDTH{in_inv[i]}};
        end
    end
`else
    assign leafEff = in_leaf;
`endif

    // A stage may load when it, or any stage after it, has a hole, or when
    // the consumer is taking the result. Written as a scan over the later
    // stages rather than a ripple on stageLoad itself so the logic has no
    // self-referencing vector.
    always_comb begin
        stageLoad = '0;
        for (int k = 0; k < LEVELS; k++) begin
            stageLoad[k] = out_ready;
            for (int m = k; m < LEVELS; m++) begin
                if (!stageValid[m]) begin
                    stageLoad[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready  = rst_n && !flush && stageLoad[0];
    assign out_valid = stageValid[LEVELS-1];
    assign busy      = |stageValid;

    for (genvar k = 0; k < LEVELS; k++) begin : gStage
        localparam int NODES = nodeCount(LEVELS, k + 1);

        logic [3*NODES*WIDTH-1:0] childData;
        logic                     childValid;
        logic [NODES*WIDTH-1:0]   nodeData;

        if (k == 0) begin : gFirst
            assign childData  = leafEff;
            assign childValid = in_valid && in_ready;
        end else begin : gNext
            assign childData  = gStage[k-1].nodeData;
            assign childValid = stageValid[k-1];
        end

        maj_tree_stage #(
            .WIDTH (WIDTH),
            .NODES (NODES)
        ) uStage (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .load       (stageLoad[k]),
            .childValid (childValid),
            .childData  (childData),
            .nodeValid  (stageValid[k]),
            .nodeData   (nodeData)
        );
    end

    assign out_data = gStage[LEVELS-1].nodeData;

endmodule

// File: tb/tb_maj_tree_pipe.sv
// tb_maj_tree_pipe
// Directed checks on a WIDTH=1 LEVELS=3 tree (latency, hand-computed leaf
// patterns, back-pressure, flush, asynchronous reset) plus a WIDTH=8 tree
// driven with random traffic against a counting majority model.
module tb_maj_tree_pipe;

    logic         clk;
    logic         rst_n;

    logic         flush1;
    logic         inValid1;
    logic         inReady1;
    logic [26:0]  leaf1;
    logic         outValid1;
    logic         outReady1;
    logic [0:0]   outData1;
    logic         busy1;
`ifdef MAJ_TREE_INV_EN
    logic [26:0]  inv1;
`endif

    logic         flush8;
    logic         inValid8;
    logic         inReady8;
    logic [215:0] leaf8;
    logic         outValid8;
    logic         outReady8;
    logic [7:0]   outData8;
    logic         busy8;
`ifdef MAJ_TREE_INV_EN
    logic [26:0]  inv8;
`endif

    int checkCount = 0;
    int missCount  = 0;

    logic [7:0] expQ [$];

    maj_tree_pipe #(.WIDTH(1), .LEVELS(3)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush1),
        .in_valid  (inValid1),
        .in_ready  (inReady1),
        .in_leaf   (leaf1),
`ifdef MAJ_TREE_INV_EN
        .in_inv    (inv1),
`endif
        .out_valid (outValid1),
        .out_ready (outReady1),
        .out_data  (outData1),
        .busy      (busy1)
    );

    maj_tree_pipe #(.WIDTH(8), .LEVELS(3)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush8),
        .in_valid  (inValid8),
        .in_ready  (inReady8),
        .in_leaf   (leaf8),
`ifdef MAJ_TREE_INV_EN
        .in_inv    (inv8),
`endif
        .out_valid (outValid8),
        .out_ready (outReady8),
        .out_data  (outData8),
        .busy      (busy8)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Majority by counting ones per bit, reducing level by level in place.
    function automatic logic [7:0] refMaj(input logic [215:0] leaves);
        logic [7:0] lvl [27];
        int cnt;
        for (int i = 0; i < 27; i++) lvl[i] = leaves[i*8 +: 8];
        for (int n = 9; n >= 1; n = n / 3) begin
            for (int j = 0; j < n; j++) begin
                for (int b = 0; b < 8; b++) begin
                    cnt = int'(lvl[3*j][b]) + int'(lvl[3*j+1][b]) + int'(lvl[3*j+2][b]);
                    lvl[j][b] = (cnt >= 2);
                end
            end
        end
        return lvl[0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive the narrow DUT's handshake inputs; settles 1 unit before returning.
    task automatic applyStimulus(input logic valid, input logic [26:0] leaves,
                                 input logic ready);
        inValid1  = valid;
        leaf1     = leaves;
        outReady1 = ready;
        #1;
    endtask

    // Offer one vector with out_ready held high and check it surfaces exactly
    // three edges after acceptance, then drains.
    task automatic sendAndWait(input string tag, input logic [26:0] leaves,
                               input logic expected);
        @(negedge clk);
        applyStimulus(1'b1, leaves, 1'b1);
        checkOutput({tag, "_in_ready"}, 64'(inReady1), 64'd1);
        @(negedge clk);
        applyStimulus(1'b0, 27'd0, 1'b1);
        checkOutput({tag, "_lat1"}, 64'(outValid1), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_lat2"}, 64'(outValid1), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 64'(outValid1), 64'd1);
        checkOutput({tag, "_data"}, 64'(outData1), 64'(expected));
        @(negedge clk);
        checkOutput({tag, "_drained"}, 64'(outValid1), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        flush1   = 1'b0;
        flush8   = 1'b0;
        inValid8 = 1'b0;
        outReady8 = 1'b0;
        leaf8    = '0;
`ifdef MAJ_TREE_INV_EN
        inv1     = '0;
        inv8     = '0;
`endif
        applyStimulus(1'b0, 27'd0, 1'b1);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 64'(inReady1), 64'd0);
        checkOutput("rst_out_valid", 64'(outValid1), 64'd0);
        checkOutput("rst_busy", 64'(busy1), 64'd0);
        checkOutput("rst_out_data", 64'(outData1), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 64'(inReady1), 64'd1);

        // Directed leaf patterns
        sendAndWait("all_ones", 27'h7FFFFFF, 1'b1);
        sendAndWait("leaves0to8", 27'h00001FF, 1'b0);
        sendAndWait("leaves_0_1_9_10_18", 27'h0040603, 1'b0);
        sendAndWait("leaves_0_1_3_4_9_10_12_13", 27'h000361B, 1'b1);
        sendAndWait("all_zero", 27'h0000000, 1'b0);

`ifdef MAJ_TREE_INV_EN
        inv1 = 27'h7FFFFFF;
        sendAndWait("inv_all", 27'h0000000, 1'b1);
        inv1 = 27'h0000000;
        sendAndWait("inv_none", 27'h0000000, 1'b0);
`endif

        // Back-pressure: four offers with out_ready low, results 1,0,1,0
        @(negedge clk);
        applyStimulus(1'b1, 27'h7FFFFFF, 1'b0);
        checkOutput("bp_accept0", 64'(inReady1), 64'd1);
        @(negedge clk);
        applyStimulus(1'b1, 27'h0000000, 1'b0);
        checkOutput("bp_accept1", 64'(inReady1), 64'd1);
        @(negedge clk);
        applyStimulus(1'b1, 27'h7FFFFFF, 1'b0);
        checkOutput("bp_accept2", 64'(inReady1), 64'd1);
        @(negedge clk);
        applyStimulus(1'b1, 27'h0000000, 1'b0);
        checkOutput("bp_full_in_ready", 64'(inReady1), 64'd0);
        checkOutput("bp_full_out_valid", 64'(outValid1), 64'd1);
        checkOutput("bp_full_data", 64'(outData1), 64'd1);
        @(negedge clk);
        checkOutput("bp_hold_in_ready", 64'(inReady1), 64'd0);
        checkOutput("bp_hold_data", 64'(outData1), 64'd1);
        applyStimulus(1'b1, 27'h0000000, 1'b1);
        checkOutput("bp_ready_comb", 64'(inReady1), 64'd1);
        @(negedge clk);
        applyStimulus(1'b0, 27'd0, 1'b1);
        checkOutput("bp_out1_valid", 64'(outValid1), 64'd1);
        checkOutput("bp_out1_data", 64'(outData1), 64'd0);
        @(negedge clk);
        checkOutput("bp_out2_valid", 64'(outValid1), 64'd1);
        checkOutput("bp_out2_data", 64'(outData1), 64'd1);
        @(negedge clk);
        checkOutput("bp_out3_valid", 64'(outValid1), 64'd1);
        checkOutput("bp_out3_data", 64'(outData1), 64'd0);
        @(negedge clk);
        checkOutput("bp_empty_valid", 64'(outValid1), 64'd0);
        checkOutput("bp_empty_busy", 64'(busy1), 64'd0);

        // Flush with two vectors in flight, plus an offer in the flush cycle
        @(negedge clk);
        applyStimulus(1'b1, 27'h7FFFFFF, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 27'h7FFFFFF, 1'b1);
        @(negedge clk);
        flush1 = 1'b1;
        applyStimulus(1'b1, 27'h7FFFFFF, 1'b1);
        checkOutput("flush_in_ready", 64'(inReady1), 64'd0);
        checkOutput("flush_busy_before", 64'(busy1), 64'd1);
        @(negedge clk);
        flush1 = 1'b0;
        applyStimulus(1'b0, 27'd0, 1'b1);
        checkOutput("flush_busy", 64'(busy1), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("flush_no_stale", 64'(outValid1), 64'd0);
        end
        sendAndWait("after_flush", 27'h7FFFFFF, 1'b1);

        // Asynchronous reset mid-cycle with two vectors in flight
        @(negedge clk);
        applyStimulus(1'b1, 27'h7FFFFFF, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 27'h7FFFFFF, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 27'd0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 64'(busy1), 64'd0);
        checkOutput("arst_out_valid", 64'(outValid1), 64'd0);
        checkOutput("arst_out_data", 64'(outData1), 64'd0);
        checkOutput("arst_in_ready", 64'(inReady1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("arst_no_stale", 64'(outValid1), 64'd0);
        end
        sendAndWait("after_reset", 27'h000361B, 1'b1);

        // WIDTH=8 random traffic against the counting model
        begin
            int sent;
            int recv;
            int cycles;
            logic [7:0] expected;
            sent   = 0;
            recv   = 0;
            cycles = 0;
            while ((sent < 1000 || recv < 1000) && cycles < 20000) begin
                @(negedge clk);
                cycles++;
                inValid8  = (sent < 1000) && ($urandom_range(0, 3) != 0);
                outReady8 = ($urandom_range(0, 1) == 1);
                for (int i = 0; i < 27; i++) leaf8[i*8 +: 8] = 8'($urandom_range(0, 255));
                #1;
                if (outValid8 && outReady8) begin
                    if (expQ.size() == 0) begin
                        checkOutput("w8_unexpected_out", 64'(outValid8), 64'd0);
                    end else begin
                        expected = expQ.pop_front();
                        checkOutput("w8_data", 64'(outData8), 64'(expected));
                    end
                    recv++;
                end
                if (inValid8 && inReady8) begin
                    expQ.push_back(refMaj(leaf8));
                    sent++;
                end
            end
            @(negedge clk);
            inValid8  = 1'b0;
            outReady8 = 1'b0;
            checkOutput("w8_sent", 64'(sent), 64'd1000);
            checkOutput("w8_recv", 64'(recv), 64'd1000);
            checkOutput("w8_queue_empty", 64'(expQ.size()), 64'd0);
            checkOutput("w8_busy_idle", 64'(busy8), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
        $finish;
    end

endmodule
